// File: rtl/imem_port_arbiter.sv
// Purpose: shares one single-port instruction RAM between the IF-stage fetch port and a read/write loader port.
// Latency: grant and memory command are combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: fetch wins contention until the loader has waited MAX_WAIT cycles; loader lock or IFLUSH deny fetch grants.
module imem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          Clock,
    input  logic          Reset_,
    input  logic          IFLUSH,
    input  logic          F_Req,
    input  logic [AW-1:0] F_Addr,
    output logic          F_Gnt,
    output logic          F_Valid,
    output logic [DW-1:0] F_Data,
    input  logic          L_Req,
    input  logic          L_We,
    input  logic          L_Lock,
    input  logic [AW-1:0] L_Addr,
    input  logic [DW-1:0] L_WData,
    output logic          L_Gnt,
    output logic          L_Valid,
    output logic [DW-1:0] L_RData,
    output logic          Locked,
    output logic          Mem_En,
    output logic          Mem_We,
    output logic [AW-1:0] Mem_Addr,
    output logic [DW-1:0] Mem_WData,
    input  logic [DW-1:0] Mem_RData
);

    typedef enum logic {
        SHARE = 1'b0,
        LOCK  = 1'b1
    } state_t;

    // Counter is 4 bits wide so any MAX_WAIT in 1..15 fits.
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       f_pend_q, f_pend_d;
    logic       l_pend_q, l_pend_d;
    logic       f_gnt, l_gnt;
    logic       f_can;

    // Grant selection: fetch priority with starvation override; lock hands the RAM to the loader.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        f_can = F_Req & ~IFLUSH;
        if (Reset_) begin
            if (state_q == LOCK) begin
                l_gnt = L_Req;
            end else if (f_can && L_Req) begin
                if (wait_q == MAX_WAIT_C) l_gnt = 1'b1;
                else                      f_gnt = 1'b1;
            end else begin
                f_gnt = f_can;
                l_gnt = L_Req;
            end
        end
    end

    // Next-state logic: lock FSM, loader wait counter and read-return pending flags.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        f_pend_d = f_gnt;
        l_pend_d = l_gnt & ~L_We;
        case (state_q)
            SHARE:   if (l_gnt && L_Lock) state_d = LOCK;
            LOCK:    if (!L_Lock)         state_d = SHARE;
            default: state_d = SHARE;
        endcase
        if (l_gnt) begin
            wait_d = 4'd0;
        end else if (L_Req && (wait_q < MAX_WAIT_C)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // State registers; an async reset drops any in-flight read so no Valid follows release.
    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            state_q  <= SHARE;
            wait_q   <= 4'd0;
            f_pend_q <= 1'b0;
            l_pend_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            f_pend_q <= f_pend_d;
            l_pend_q <= l_pend_d;
        end
    end

    // Memory command mux and read-data steering; a flush in the return cycle yields a zero bubble.
    always_comb begin
        F_Gnt     = f_gnt;
        L_Gnt     = l_gnt;
        Mem_En    = f_gnt | l_gnt;
        Mem_We    = l_gnt & L_We;
        Mem_Addr  = '0;
        Mem_WData = '0;
        if (l_gnt) begin
            Mem_Addr  = L_Addr;
            Mem_WData = L_WData;
        end else if (f_gnt) begin
            Mem_Addr  = F_Addr;
        end
        F_Valid = f_pend_q & ~IFLUSH;
        F_Data  = F_Valid ? Mem_RData : '0;
        L_Valid = l_pend_q;
        L_RData = L_Valid ? Mem_RData : '0;
        Locked  = (state_q == LOCK);
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Purpose: self-checking bench for imem_port_arbiter with a behavioural single-port RAM and return-data scoreboard.
// Latency: inputs driven just after the falling edge, outputs sampled 1ns later; read data checked the cycle after grant.
// Backpressure: directed contention, flush, lock and reset sequences drive the arbitration corners.
module tb_imem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset_;
    logic          IFLUSH;
    logic          F_Req;
    logic [AW-1:0] F_Addr;
    logic          F_Gnt, F_Valid;
    logic [DW-1:0] F_Data;
    logic          L_Req, L_We, L_Lock;
    logic [AW-1:0] L_Addr;
    logic [DW-1:0] L_WData;
    logic          L_Gnt, L_Valid;
    logic [DW-1:0] L_RData;
    logic          Locked, Mem_En, Mem_We;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_WData;
    logic [DW-1:0] Mem_RData = '0;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] lq[$];
    int checks = 0;
    int errors = 0;

    imem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
        .Clock(Clock), .Reset_(Reset_), .IFLUSH(IFLUSH),
        .F_Req(F_Req), .F_Addr(F_Addr), .F_Gnt(F_Gnt), .F_Valid(F_Valid), .F_Data(F_Data),
        .L_Req(L_Req), .L_We(L_We), .L_Lock(L_Lock), .L_Addr(L_Addr), .L_WData(L_WData),
        .L_Gnt(L_Gnt), .L_Valid(L_Valid), .L_RData(L_RData), .Locked(Locked),
        .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData)
    );

    always #5 Clock = ~Clock;

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge Clock) begin
        if (Mem_En) begin
            if (Mem_We) ram[Mem_Addr] <= Mem_WData;
            else        Mem_RData <= ram[Mem_Addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        IFLUSH = 1'b0; F_Req = 1'b0; F_Addr = '0;
        L_Req = 1'b0; L_We = 1'b0; L_Lock = 1'b0; L_Addr = '0; L_WData = '0;
    endtask

    task automatic go();
        @(negedge Clock);
    endtask

    // Let combinational outputs settle, then retire any returned read against the scoreboard.
    task automatic settle();
        #1;
        if (F_Valid) begin
            if (fq.size() == 0) chk("f_unexpected_valid", 32'd1, 32'd0);
            else                chk("f_data", F_Data, fq.pop_front());
        end
        if (L_Valid) begin
            if (lq.size() == 0) chk("l_unexpected_valid", 32'd1, 32'd0);
            else                chk("l_rdata", L_RData, lq.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram[8'h10] = 32'h8C220004;
        ram[8'h11] = 32'h11111111;

        // Reset: requests present but grants and all outputs held at zero.
        Reset_ = 1'b0;
        idle_in();
        F_Req = 1'b1; L_Req = 1'b1;
        #2;
        chk("rst_f_gnt", 32'(F_Gnt), 32'd0);
        chk("rst_l_gnt", 32'(L_Gnt), 32'd0);
        chk("rst_mem_en", 32'(Mem_En), 32'd0);
        chk("rst_locked", 32'(Locked), 32'd0);
        chk("rst_f_valid", 32'(F_Valid), 32'd0);
        chk("rst_l_valid", 32'(L_Valid), 32'd0);
        go(); Reset_ = 1'b1; idle_in(); settle();

        // Fetch only.
        go(); F_Req = 1'b1; F_Addr = 8'h10; settle();
        chk("f1_gnt", 32'(F_Gnt), 32'd1);
        chk("f1_mem_addr", 32'(Mem_Addr), 32'h10);
        chk("f1_mem_we", 32'(Mem_We), 32'd0);
        fq.push_back(32'h8C220004);
        go(); idle_in(); settle();
        chk("f1_valid", 32'(F_Valid), 32'd1);
        chk("f1_data", F_Data, 32'h8C220004);

        // Starvation: fetch wins four contended cycles, loader the fifth, fetch again the sixth.
        for (int c = 1; c <= 6; c++) begin
            go();
            F_Req = 1'b1; F_Addr = 8'h11;
            L_Req = 1'b1; L_We = 1'b1; L_Addr = 8'h20; L_WData = 32'hDEADBEEF;
            settle();
            chk($sformatf("starve_f_gnt_c%0d", c), 32'(F_Gnt), (c == 5) ? 32'd0 : 32'd1);
            chk($sformatf("starve_l_gnt_c%0d", c), 32'(L_Gnt), (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                chk("starve_mem_we", 32'(Mem_We), 32'd1);
                chk("starve_mem_addr", 32'(Mem_Addr), 32'h20);
                chk("starve_mem_wdata", Mem_WData, 32'hDEADBEEF);
            end else begin
                fq.push_back(32'h11111111);
            end
        end
        go(); idle_in(); settle();
        chk("starve_l_valid_on_write", 32'(L_Valid), 32'd0);

        // Flush in the return cycle and in the issue cycle.
        go(); F_Req = 1'b1; F_Addr = 8'h10; settle();
        chk("flush_issue_gnt", 32'(F_Gnt), 32'd1);
        go(); IFLUSH = 1'b1; settle();
        chk("flush_ret_valid", 32'(F_Valid), 32'd0);
        chk("flush_ret_data", F_Data, 32'd0);
        chk("flush_same_gnt", 32'(F_Gnt), 32'd0);
        chk("flush_same_mem_en", 32'(Mem_En), 32'd0);
        go(); idle_in(); settle();
        chk("flush_no_late_valid", 32'(F_Valid), 32'd0);

        // Lock burst: eight loader writes, fetch locked out, release then fetch resumes.
        for (int k = 0; k < 8; k++) begin
            go();
            F_Req = (k > 0); F_Addr = 8'h10;
            L_Req = 1'b1; L_Lock = 1'b1; L_We = 1'b1; L_Addr = 8'(k); L_WData = 32'hC0DE0000 + 32'(k);
            settle();
            chk($sformatf("lock_l_gnt_%0d", k), 32'(L_Gnt), 32'd1);
            chk($sformatf("lock_f_gnt_%0d", k), 32'(F_Gnt), 32'd0);
            chk($sformatf("lock_locked_%0d", k), 32'(Locked), (k > 0) ? 32'd1 : 32'd0);
        end
        go(); L_Req = 1'b0; L_Lock = 1'b0; L_We = 1'b0; F_Req = 1'b1; F_Addr = 8'h03; settle();
        chk("lock_release_locked", 32'(Locked), 32'd1);
        chk("lock_release_f_gnt", 32'(F_Gnt), 32'd0);
        go(); settle();
        chk("unlock_locked", 32'(Locked), 32'd0);
        chk("unlock_f_gnt", 32'(F_Gnt), 32'd1);
        fq.push_back(32'hC0DE0003);
        go(); idle_in(); settle();

        // Loader write then read-back.
        go(); L_Req = 1'b1; L_We = 1'b1; L_Addr = 8'h05; L_WData = 32'h12345678; settle();
        chk("lw_gnt", 32'(L_Gnt), 32'd1);
        chk("lw_mem_we", 32'(Mem_We), 32'd1);
        go(); L_We = 1'b0; L_WData = '0; settle();
        chk("lr_gnt", 32'(L_Gnt), 32'd1);
        chk("lr_mem_we", 32'(Mem_We), 32'd0);
        chk("lw_no_valid", 32'(L_Valid), 32'd0);
        lq.push_back(32'h12345678);
        go(); idle_in(); settle();
        chk("lr_valid", 32'(L_Valid), 32'd1);
        chk("lr_rdata", L_RData, 32'h12345678);

        // Async reset with a fetch in flight and the wait counter non-zero.
        go(); F_Req = 1'b1; F_Addr = 8'h10; L_Req = 1'b1; L_Addr = 8'h30; settle();
        chk("ar_pre_f_gnt", 32'(F_Gnt), 32'd1);
        go(); Reset_ = 1'b0; settle();
        chk("ar_f_valid", 32'(F_Valid), 32'd0);
        chk("ar_f_data", F_Data, 32'd0);
        chk("ar_f_gnt", 32'(F_Gnt), 32'd0);
        chk("ar_l_gnt", 32'(L_Gnt), 32'd0);
        chk("ar_mem_en", 32'(Mem_En), 32'd0);
        go(); Reset_ = 1'b1; idle_in(); settle();
        chk("ar_post_f_valid", 32'(F_Valid), 32'd0);
        chk("ar_post_l_valid", 32'(L_Valid), 32'd0);
        chk("ar_post_locked", 32'(Locked), 32'd0);
        // Counter restarted from zero: loader must wait the full four contended cycles again.
        for (int i = 0; i < 5; i++) begin
            go();
            F_Req = 1'b1; F_Addr = 8'h10;
            L_Req = 1'b1; L_We = 1'b1; L_Addr = 8'h40; L_WData = 32'(i);
            settle();
            chk($sformatf("ar_cnt_f_gnt_%0d", i), 32'(F_Gnt), (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("ar_cnt_l_gnt_%0d", i), 32'(L_Gnt), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) fq.push_back(32'h8C220004);
        end
        go(); idle_in(); settle();

        // Async reset while locked.
        go(); L_Req = 1'b1; L_Lock = 1'b1; L_We = 1'b1; L_Addr = 8'h41; settle();
        chk("arl_l_gnt", 32'(L_Gnt), 32'd1);
        go(); settle();
        chk("arl_locked", 32'(Locked), 32'd1);
        go(); Reset_ = 1'b0; settle();
        chk("arl_rst_locked", 32'(Locked), 32'd0);
        chk("arl_rst_l_gnt", 32'(L_Gnt), 32'd0);
        chk("arl_rst_mem_en", 32'(Mem_En), 32'd0);
        go(); Reset_ = 1'b1; idle_in(); settle();
        chk("arl_post_locked", 32'(Locked), 32'd0);
        go(); F_Req = 1'b1; F_Addr = 8'h11; settle();
        chk("arl_post_f_gnt", 32'(F_Gnt), 32'd1);
        fq.push_back(32'h11111111);
        go(); idle_in(); settle();

        chk("fq_drained", 32'(fq.size()), 32'd0);
        chk("lq_drained", 32'(lq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous instruction memory (2^AW x DW) between two requesters:
  - Fetch port: the IF stage, read-only.
  - Loader port: program download and debug, read/write.
- Sits between the IF stage / loader and the instruction RAM.
- Fetch has priority. A starvation counter guarantees the loader progresses.
- A lock mode lets the loader own the memory for burst program download.
- IFLUSH turns an in-flight fetch into a zero bubble.

Parameters:
AW, 8, address width (memory depth 2^AW words)
DW, 32, data width
MAX_WAIT, 4, loader denied cycles before it wins contention (1..15)

Ports:
Clock  in  1  clock
Reset_  in  1  reset, asynchronous, active-low
IFLUSH  in  1  flush: cancels fetch issue/return this cycle
F_Req  in  1  fetch read request
F_Addr  in  AW  fetch address (PC word index)
F_Gnt  out  1  fetch granted, command issued this cycle
F_Valid  out  1  fetch read data valid
F_Data  out  DW  fetch read data (0 when F_Valid=0)
L_Req  in  1  loader request
L_We  in  1  loader write (1) / read (0)
L_Lock  in  1  loader requests exclusive ownership
L_Addr  in  AW  loader address
L_WData  in  DW  loader write data
L_Gnt  out  1  loader granted, command issued this cycle
L_Valid  out  1  loader read data valid
L_RData  out  DW  loader read data (0 when L_Valid=0)
Locked  out  1  arbiter in LOCK state
Mem_En  out  1  memory access enable
Mem_We  out  1  memory write enable
Mem_Addr  out  AW  memory address
Mem_WData  out  DW  memory write data
Mem_RData  in  DW  memory read data, valid the cycle after Mem_En&!Mem_We

Behaviour:
- Reset (Reset_=0, async):
  - State=SHARE.
  - Wait counter=0.
  - Pending flags F_Pend and L_Pend cleared.
  - All outputs 0; grants forced 0 while Reset_=0.
- Grant selection is combinational, evaluated every cycle; at most one grant per cycle.
  - SHARE state, priority order:
    - IFLUSH blocks fetch: F_Gnt=0.
    - Otherwise, if only one port is requesting, that port is granted.
    - On contention, fetch wins unless the wait counter == MAX_WAIT, in which case the loader wins.
  - LOCK state:
    - F_Gnt=0 always.
    - L_Gnt=L_Req.
- Memory command:
  - Mem_En=F_Gnt|L_Gnt.
  - Mem_We=L_Gnt&L_We.
  - Mem_Addr and Mem_WData are muxed from the granted port; both are 0 when idle.
- Wait counter:
  - Increments (saturating at MAX_WAIT) when L_Req&!L_Gnt.
  - Clears on L_Gnt.
  - Holds otherwise.
- Read latency is 1 cycle.
  - F_Pend<=F_Gnt; L_Pend<=L_Gnt&!L_We.
  - F_Valid=F_Pend&!IFLUSH; F_Data=F_Valid?Mem_RData:0.
  - L_Valid=L_Pend; L_RData=L_Valid?Mem_RData:0.
- Flush:
  - IFLUSH in the return cycle suppresses F_Valid; F_Data=0, a bubble equivalent to IR0=0.
  - IFLUSH in the issue cycle denies the fetch grant.
  - Loader traffic is unaffected by IFLUSH.
- Loader writes: no data returned. A write followed by a read of the same address returns the new data.
- State machine:
  - SHARE->LOCK on a clock edge with L_Gnt&L_Lock.
  - LOCK->SHARE on a clock edge with L_Lock=0.
  - The release cycle itself (L_Lock=0 while in LOCK) still follows LOCK rules; fetch is re-enabled the next cycle.
  - Locked=1 iff state=LOCK.
- Reset mid-operation: pending reads are discarded, no Valid is produced after reset release, and the state returns to SHARE.
- Simultaneous F_Req and L_Req with the counter below MAX_WAIT: fetch granted, counter increments.

Test Plan:
- Fetch only: F_Req=1, F_Addr=0x10, Mem_RData=0x8C220004 next cycle -> F_Gnt=1, Mem_Addr=0x10, Mem_We=0; next cycle F_Valid=1, F_Data=0x8C220004.
- Starvation, MAX_WAIT=4: F_Req and L_Req (write, addr 0x20, data 0xDEADBEEF) held continuously -> F_Gnt on cycles 1-4; cycle 5 L_Gnt=1, Mem_We=1, Mem_Addr=0x20; counter=0 afterwards; cycle 6 fetch granted again.
- Flush: F_Gnt at cycle N, IFLUSH=1 at N+1 -> F_Valid=0, F_Data=0 at N+1; IFLUSH with F_Req in the same cycle -> F_Gnt=0, Mem_En=0.
- Lock burst: L_Req=L_Lock=L_We=1 writing addresses 0..7 while F_Req=1 -> Locked=1 from cycle 2; 8 consecutive L_Gnt, F_Gnt=0 throughout; drop L_Lock -> Locked=0 next cycle; fetch granted the cycle after.
- Loader read-back: write 0x12345678 to 0x05, then read 0x05 -> L_Valid=1, L_RData=0x12345678 one cycle after the read grant.
- Async reset asserted while F_Pend=1 and Locked=1 -> all outputs 0 immediately; after release, no F_Valid, Locked=0, counter=0.
